falu_sched: RTL

Issue scheduler and FCSR0 owner for the shared floating-point ALU. It arbitrates round-robin between two micro-op requesters and drives one registered issue slot into the fixed-latency FP datapath. It tracks in-flight operations so writeback carries the destination register and requester id. It serializes FCSR0 writes so that a rounding-mode change never affects an operation already issued.

---
 rtl/falu_sched.sv | 131 +++++++++++++
 1 files changed

// File: rtl/falu_sched.sv
// falu_sched: round-robin issue scheduler and FCSR0 owner for the shared FP ALU
// Optional feature macro FALU_SCHED_FLAGS_EN: ResFlags accumulate sticky into Fcsr0[20:16].
// Ports: Clk/Rest (sync, active-high); Req0*/Req1* requester handshake and payload;
//   FcsrWr* FCSR0 write handshake; Issue* registered issue slot; Fcsr0 current CSR;
//   ResFlags/Wb* writeback tagging; Busy ops in flight or write pending.
module falu_sched #(
    parameter int WIDTH_FALU = 32,
    parameter int LAT        = 3,
    parameter int REG_W      = 5,
    parameter int OP_W       = 8
) (
    input  logic                    Clk,
    input  logic                    Rest,
    input  logic                    Req0Valid,
    output logic                    Req0Ready,
    input  logic [OP_W-1:0]         Req0Op,
    input  logic [2*WIDTH_FALU-1:0] Req0Src1,
    input  logic [2*WIDTH_FALU-1:0] Req0Src2,
    input  logic [REG_W-1:0]        Req0Rd,
    input  logic                    Req1Valid,
    output logic                    Req1Ready,
    input  logic [OP_W-1:0]         Req1Op,
    input  logic [2*WIDTH_FALU-1:0] Req1Src1,
    input  logic [2*WIDTH_FALU-1:0] Req1Src2,
    input  logic [REG_W-1:0]        Req1Rd,
    input  logic                    FcsrWrValid,
    input  logic [WIDTH_FALU-1:0]   FcsrWrData,
    output logic                    FcsrWrReady,
    output logic                    IssueValid,
    output logic [OP_W-1:0]         IssueOp,
    output logic [2*WIDTH_FALU-1:0] IssueSrc1,
    output logic [2*WIDTH_FALU-1:0] IssueSrc2,
    output logic [WIDTH_FALU-1:0]   Fcsr0,
    input  logic [4:0]              ResFlags,
    output logic                    WbValid,
    output logic [REG_W-1:0]        WbRd,
    output logic                    WbReqId,
    output logic                    Busy
);
    localparam int CW = $clog2(LAT + 2);
    localparam int TW = REG_W + 2;
`ifdef FALU_SCHED_FLAGS_EN
    localparam logic [WIDTH_FALU-1:0] WR_MASK = WIDTH_FALU'(32'h001F_031F);
`else
    localparam logic [WIDTH_FALU-1:0] WR_MASK = WIDTH_FALU'(32'h0000_031F);
    logic unused_flags;
    assign unused_flags = ^ResFlags;
`endif

    typedef enum logic [1:0] {IDLE, DRAIN, WRITE} state_t;

    state_t          state, state_nxt;
    logic            ptr;
    logic            grant0, grant1;
    logic [CW-1:0]   inflight;
    logic [REG_W-1:0] issue_rd;
    logic            issue_id;
    logic [TW-1:0]   trk [LAT];

    always_ff @(posedge Clk) begin
        state <= Rest ? IDLE : state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        Req0Ready   = 1'b0;
        Req1Ready   = 1'b0;
        FcsrWrReady = 1'b0;
        case (state)
            IDLE: begin
                if (FcsrWrValid) begin
                    state_nxt = DRAIN;
                end else begin
                    Req0Ready = ~ptr | ~Req1Valid;
                    Req1Ready = ptr | ~Req0Valid;
                end
            end
            DRAIN: state_nxt = (inflight == '0 && !IssueValid) ? WRITE : DRAIN;
            WRITE: begin
                state_nxt   = IDLE;
                FcsrWrReady = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (Rest) begin
            Req0Ready   = 1'b0;
            Req1Ready   = 1'b0;
            FcsrWrReady = 1'b0;
        end
    end

    // With both valid exactly one ready is high, so at most one grant per cycle.
    assign grant0 = Req0Valid & Req0Ready;
    assign grant1 = Req1Valid & Req1Ready & ~grant0;

    always_ff @(posedge Clk) begin
        if (Rest) begin
            ptr        <= 1'b0;
            IssueValid <= 1'b0;
            IssueOp    <= '0;
            IssueSrc1  <= '0;
            IssueSrc2  <= '0;
            issue_rd   <= '0;
            issue_id   <= 1'b0;
            inflight   <= '0;
            Fcsr0      <= '0;
            for (int i = 0; i < LAT; i++) trk[i] <= '0;
        end else begin
            IssueValid <= grant0 | grant1;
            if (grant0 | grant1) begin
                ptr       <= grant0;
                IssueOp   <= grant0 ? Req0Op : Req1Op;
                IssueSrc1 <= grant0 ? Req0Src1 : Req1Src1;
                IssueSrc2 <= grant0 ? Req0Src2 : Req1Src2;
                issue_rd  <= grant0 ? Req0Rd : Req1Rd;
                issue_id  <= grant1;
            end
            trk[0] <= {IssueValid, issue_rd, issue_id};
            for (int i = 1; i < LAT; i++) trk[i] <= trk[i-1];
            inflight <= inflight + CW'(IssueValid) - CW'(WbValid);
            // The pipe is empty in WRITE, so a CSR write never meets a flag update.
            if (FcsrWrReady) Fcsr0 <= (Fcsr0 & ~WR_MASK) | (FcsrWrData & WR_MASK);
`ifdef FALU_SCHED_FLAGS_EN
            else if (WbValid) Fcsr0[20:16] <= Fcsr0[20:16] | ResFlags;
`endif
        end
    end

    assign {WbValid, WbRd, WbReqId} = trk[LAT-1];
    assign Busy = ~Rest & ((state != IDLE) | IssueValid | (inflight != '0));
endmodule
